// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory: funct3 access codes,
// FSM state encoding and small address helpers.
package dmem_pkg;

    // RISC-V load/store funct3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when the low address bits do not match the natural alignment of the access
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            F3_H, F3_HU: mis = lo[0];
            F3_W:        mis = |lo;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Clear the low address bits that fall inside the access width
    function automatic logic [1:0] align_down(input logic [2:0] size, input logic [1:0] lo);
        logic [1:0] al;
        case (size)
            F3_H, F3_HU: al = {lo[1], 1'b0};
            F3_W:        al = 2'b00;
            default:     al = lo;
        endcase
        return al;
    endfunction

    // Number of bytes touched by an access (1, 2 or 4)
    function automatic logic [2:0] access_bytes(input logic [2:0] size);
        logic [2:0] n;
        case (size[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: synchronous write, asynchronous read.
// Contents are never reset.
module dmem_bank #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata
);

    logic [7:0] mem [2**DEPTH_W];

    // Commit the lane byte when its write enable is set
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_banked.sv
// Banked byte-addressable data memory with a fixed-latency request/response
// interface. Four byte-lane banks hold the array; the FSM walks
// IDLE -> WAIT (LATENCY cycles, skipped when LATENCY=0) -> RESP -> IDLE.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE and never during reset. The response is a
// one-cycle rsp_valid pulse; rsp_rdata/rsp_err hold until the next response.
//
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word
// accesses; otherwise misaligned accesses are aligned down and complete.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         WORD_W    = ADDR_W - 2;
    localparam logic       ZERO_LAT  = (LATENCY == 0);
    localparam logic [2:0] WAIT_LAST = 3'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t      state;
    logic [2:0]  wait_cnt;

    logic        q_write;
    logic [31:0] q_addr;
    logic [2:0]  q_size;
    logic [31:0] q_wdata;

    logic        accept;
    logic        access;
    logic        a_write;
    logic [31:0] a_addr;
    logic [2:0]  a_size;
    logic [31:0] a_wdata;

    logic        size_err;
    logic        range_err;
    logic        misalign_err;
    logic        err;
    logic [1:0]  lo;
    logic [32:0] last_byte;

    logic [WORD_W-1:0] word_idx;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata;
    logic [31:0]       word;
    logic [31:0]       load_data;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign req_ready = (state == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // The array is touched on the edge entering RESP. With zero latency that
    // is the accept edge itself, so the live request fields drive the access.
    assign access = (accept && ZERO_LAT) ||
                    (!reset && state == ST_WAIT && wait_cnt == WAIT_LAST);

    assign a_write = (state == ST_IDLE) ? req_write : q_write;
    assign a_addr  = (state == ST_IDLE) ? req_addr  : q_addr;
    assign a_size  = (state == ST_IDLE) ? req_size  : q_size;
    assign a_wdata = (state == ST_IDLE) ? req_wdata : q_wdata;

    // Legal funct3 codes; unsigned variants are load-only
    always_comb begin
        size_err = 1'b1;
        case (a_size)
            F3_B, F3_H, F3_W: size_err = 1'b0;
            F3_BU, F3_HU:     size_err = a_write;
            default:          size_err = 1'b1;
        endcase
    end

    // Range is judged on the requested address, so a word straddling the top fails
    assign last_byte = {1'b0, a_addr} + {30'b0, access_bytes(a_size)} - 33'd1;
    assign range_err = |last_byte[32:ADDR_W];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_err = is_misaligned(a_size, a_addr[1:0]);
    assign lo           = a_addr[1:0];
`else
    assign misalign_err = 1'b0;
    assign lo           = align_down(a_size, a_addr[1:0]);
`endif

    assign err      = size_err || range_err || misalign_err;
    assign word_idx = a_addr[ADDR_W-1:2];

    // Lane enables and replicated store data; nothing is written on a fault
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = a_wdata;
        case (a_size[1:0])
            2'b00: begin
                lane_we    = 4'b0001 << lo;
                lane_wdata = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                lane_we    = lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{a_wdata[15:0]}};
            end
            default: lane_we = 4'b1111;
        endcase
        if (!(access && a_write && !err)) begin
            lane_we = 4'b0000;
        end
    end

    // Select and extend the loaded byte/halfword/word
    always_comb begin
        load_data = 32'b0;
        byte_sel  = word[{lo, 3'b000} +: 8];
        half_sel  = lo[1] ? word[31:16] : word[15:0];
        case (a_size)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = 32'b0;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        dmem_bank #(.DEPTH_W(WORD_W)) u_bank (
            .clk   (clk),
            .we    (lane_we[g]),
            .addr  (word_idx),
            .wdata (lane_wdata[8*g +: 8]),
            .rdata (word[8*g +: 8])
        );
    end

    // Capture request fields on acceptance for use during WAIT
    always_ff @(posedge clk) begin
        if (accept) begin
            q_write <= req_write;
            q_addr  <= req_addr;
            q_size  <= req_size;
            q_wdata <= req_wdata;
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wait_cnt <= 3'd0;
                        state    <= ZERO_LAT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (access) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (err || a_write) ? 32'b0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked. Two instances share the request inputs:
// dut_a with LATENCY=3 and dut_z with LATENCY=0, both ADDR_W=10.
module tb_dmem_banked;

    localparam int LAT_A = 3;
    localparam int LAT_Z = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_wdata = 32'h0;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_ready_z, rsp_valid_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    dmem_banked #(.ADDR_W(10), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
        .rsp_err(rsp_err_a)
    );

    dmem_banked #(.ADDR_W(10), .LATENCY(LAT_Z)) dut_z (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_z),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z),
        .rsp_err(rsp_err_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive one request into both instances and check both responses
    task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input logic [31:0] exp_a, input logic exp_err_a,
                         input logic [31:0] exp_z, input logic exp_err_z);
        int n, first_a, first_z, hits_a, hits_z;
        logic [31:0] cap_a, cap_z;
        logic cerr_a, cerr_z;
        n = 0; first_a = 0; first_z = 0; hits_a = 0; hits_z = 0;
        cap_a = 32'hx; cap_z = 32'hx; cerr_a = 1'bx; cerr_z = 1'bx;
        @(negedge clk);
        while (!req_ready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_a"}, 32'(req_ready_a), 32'd1);
        check({tag, "_ready_z"}, 32'(req_ready_z), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_size  = 3'($urandom_range(0, 7));
        req_wdata = $urandom;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_valid_a) begin
                hits_a++;
                if (first_a == 0) first_a = k;
                cap_a = rsp_rdata_a;
                cerr_a = rsp_err_a;
            end
            if (rsp_valid_z) begin
                hits_z++;
                if (first_z == 0) first_z = k;
                cap_z = rsp_rdata_z;
                cerr_z = rsp_err_z;
            end
        end
        check({tag, "_lat_a"}, 32'(first_a), 32'(LAT_A + 1));
        check({tag, "_lat_z"}, 32'(first_z), 32'(LAT_Z + 1));
        check({tag, "_pulse_a"}, 32'(hits_a), 32'd1);
        check({tag, "_pulse_z"}, 32'(hits_z), 32'd1);
        check({tag, "_rdata_a"}, cap_a, exp_a);
        check({tag, "_rdata_z"}, cap_z, exp_z);
        check({tag, "_err_a"}, 32'(cerr_a), 32'(exp_err_a));
        check({tag, "_err_z"}, 32'(cerr_z), 32'(exp_err_z));
        check({tag, "_hold_a"}, rsp_rdata_a, exp_a);
        check({tag, "_hold_z"}, rsp_rdata_z, exp_z);
    endtask

    task automatic issue2(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp, input logic exp_err);
        issue(tag, wr, addr, size, wdata, exp, exp_err, exp, exp_err);
    endtask

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int hits;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_a", 32'(req_ready_a), 32'd0);
        check("rst_ready_z", 32'(req_ready_z), 32'd0);
        check("rst_valid_a", 32'(rsp_valid_a), 32'd0);
        check("rst_rdata_a", rsp_rdata_a, 32'd0);
        check("rst_err_a", 32'(rsp_err_a), 32'd0);
        check("rst_rdata_z", rsp_rdata_z, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_ready_a", 32'(req_ready_a), 32'd1);
        check("rel_ready_z", 32'(req_ready_z), 32'd1);

        // Word store/load and extensions
        issue2("sw_10",  1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
        issue2("lw_10",  1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
        issue2("lb_13",  1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
        issue2("lbu_13", 1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0);
        issue2("lh_12",  1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0);
        issue2("lhu_10", 1'b0, 32'h10, 3'b101, 32'h0, 32'h0000BEEF, 1'b0);

        // Byte store touches only its lane
        issue2("sb_11",  1'b1, 32'h11, 3'b000, 32'hFFFFFF55, 32'h0, 1'b0);
        issue2("lw_10b", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0);

        // Halfword store in the upper half
        issue2("sw_14",  1'b1, 32'h14, 3'b010, 32'h0, 32'h0, 1'b0);
        issue2("sh_16",  1'b1, 32'h16, 3'b001, 32'h12348001, 32'h0, 1'b0);
        issue2("lw_14",  1'b0, 32'h14, 3'b010, 32'h0, 32'h80010000, 1'b0);
        issue2("lh_16",  1'b0, 32'h16, 3'b001, 32'h0, 32'hFFFF8001, 1'b0);

        // Top of array
        issue2("sw_3fc", 1'b1, 32'h3FC, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
        issue2("lw_3fe", 1'b0, 32'h3FE, 3'b010, 32'h0, 32'h0, 1'b1);
        issue2("sw_400", 1'b1, 32'h400, 3'b010, 32'h11111111, 32'h0, 1'b1);
        issue2("lw_3fc", 1'b0, 32'h3FC, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);
        issue2("lw_hi",  1'b0, 32'h80000010, 3'b010, 32'h0, 32'h0, 1'b1);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
        issue2("lw_12",  1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1);
        issue2("lh_11",  1'b0, 32'h11, 3'b001, 32'h0, 32'h0, 1'b1);
`else
        issue2("lw_12",  1'b0, 32'h12, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0);
        issue2("lh_11",  1'b0, 32'h11, 3'b001, 32'h0, 32'h000055EF, 1'b0);
`endif

        // Illegal size codes
        issue2("sbu_10", 1'b1, 32'h10, 3'b100, 32'h00000077, 32'h0, 1'b1);
        issue2("lw_10c", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0);
        issue2("ld_011", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
        issue2("ld_110", 1'b0, 32'h10, 3'b110, 32'h0, 32'h0, 1'b1);

        // Reset during WAIT aborts the slow instance's store
        issue2("sw_20",  1'b1, 32'h20, 3'b010, 32'h12345678, 32'h0, 1'b0);
        issue2("lw_20",  1'b0, 32'h20, 3'b010, 32'h0, 32'h12345678, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_size  = 3'b010;
        req_wdata = 32'h00000001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_busy_a", 32'(req_ready_a), 32'd0);
        reset = 1'b1;
        hits = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid_a) hits++;
        end
        check("abort_rst_ready_a", 32'(req_ready_a), 32'd0);
        check("abort_rst_rdata_a", rsp_rdata_a, 32'd0);
        check("abort_rst_err_a", 32'(rsp_err_a), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_rel_ready_a", 32'(req_ready_a), 32'd1);
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_a) hits++;
        end
        check("abort_no_rsp_a", 32'(hits), 32'd0);
        issue("lw_20_after", 1'b0, 32'h20, 3'b010, 32'h0,
              32'h12345678, 1'b0, 32'h00000001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
